mbscore_mem_responder: RTL

//  Memory-side responder for the core's shared memory bus: decodes addr/ram_re/ram_we

---
 rtl/mbscore_mem_responder_if.sv | 21 ++
 rtl/mbscore_mem_responder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mbscore_mem_responder_if.sv
// Request/response signals between the core bus controller and the memory
// responder. The shared data bus is tri-stated, so it stays a plain inout
// port on the responder rather than living in this interface.
//
// Handshake: the controller holds ram_re or ram_we (with a stable address)
// until it sees ready. ready is a one-cycle pulse that marks the end of the
// access. busy stays high from the cycle after the request is accepted until
// ready. If the request drops while busy is high and before ready, the access
// is abandoned and ready never arrives.
interface mbscore_mem_responder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ram_re;
  logic                  ram_we;
  logic                  ready;
  logic                  busy;

  modport master (output addr, output ram_re, output ram_we, input ready, input busy);
  modport slave  (input addr, input ram_re, input ram_we, output ready, output busy);
endinterface

// File: rtl/mbscore_mem_responder.sv
// Memory-side responder for the shared core bus. It holds a word-organised
// RAM and adds programmable wait states. It sends back a one-cycle ready
// pulse, and it drives the shared data bus only while a read response is in
// progress.
module mbscore_mem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_AW      = 10,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mbscore_mem_responder_if.slave bus,
  inout  wire  [DATA_WIDTH-1:0]  data,
  output logic [1:0]             o_dbg_state,
  output logic                   o_dbg_data_oe
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The counter is loaded with the number of wait cycles that still follow
  // the first WAIT cycle. A value of 0 therefore means "go to RESP on the
  // next edge".
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [MEM_AW-1:0]     r_idx;
  logic                  r_op_wr;
  logic [DATA_WIDTH-1:0] r_rd_latch;
  logic [DATA_WIDTH-1:0] r_mem [0:(1<<MEM_AW)-1];

  logic                  w_hit;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_op_held;
  logic [MEM_AW-1:0]     w_addr_idx;
  logic [MEM_AW-1:0]     w_rd_idx;
  logic                  w_drive;
  logic [1:0]            w_unused_addr_lsb;

  // Only whole-word accesses are supported, so the byte offset is ignored.
  assign w_unused_addr_lsb = bus.addr[1:0];
  assign w_addr_idx        = bus.addr[MEM_AW+1:2];
  assign w_hit             = (bus.addr[ADDR_WIDTH-1:MEM_AW+2] == BASE_ADDR[ADDR_WIDTH-1:MEM_AW+2]);
  assign w_req             = bus.ram_re | bus.ram_we;
  // The request for the latched operation must stay asserted during WAIT.
  assign w_op_held         = r_op_wr ? bus.ram_we : bus.ram_re;
  // With zero wait states the RAM is read on the accept edge, before the
  // word index has been latched, so the live address is used then.
  assign w_rd_idx          = (r_state == S_IDLE) ? w_addr_idx : r_idx;

  // Next-state decode: accept in IDLE, count or abort in WAIT, RESP lasts one cycle.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && w_hit) begin
          w_accept = 1'b1;
          w_next   = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_op_held)          w_next = S_IDLE;
        else if (r_cnt == 4'd0)  w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter and the operation latched when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_op_wr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= WAIT_INIT;
        r_idx   <= w_addr_idx;
        r_op_wr <= bus.ram_we;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Read latch is loaded on the edge that enters RESP, so data is stable for the whole RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_latch <= '0;
    end else if (w_next == S_RESP) begin
      r_rd_latch <= r_mem[w_rd_idx];
    end
  end

  // RAM write on the edge leaving RESP, using bus data sampled during RESP; RAM has no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_op_wr) begin
      r_mem[r_idx] <= data;
    end
  end

  // Write requests win over reads. The responder therefore never drives the
  // bus while ram_we is high, even if it is in a read response.
  assign w_drive       = (r_state == S_RESP) && !r_op_wr && !bus.ram_we;
  assign data          = w_drive ? r_rd_latch : {DATA_WIDTH{1'bz}};

  assign bus.ready     = (r_state == S_RESP);
  assign bus.busy      = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;
  assign o_dbg_data_oe = w_drive;

endmodule
